// File: rtl/dcc_packet_gen.sv
// DCC packet framer: preamble, start-separated bytes, XOR check byte, end bit.
// Single load buffer, per-packet repeat count and idle-packet fill.
module dcc_packet_gen #(
  parameter int PREAMBLE_BITS = 14,
  parameter int MAX_BYTES     = 5,
  parameter int REPEAT        = 1,
  parameter int LEN_W         = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*MAX_BYTES-1:0] pkt_data,
  input  logic [LEN_W-1:0]       pkt_len,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  output logic                   pkt_err,
  output logic                   pkt_done,
  output logic                   busy_user,
  input  logic                   ack,
  output logic                   next_bit
);

  localparam int AB = (MAX_BYTES < 2) ? 2 : MAX_BYTES;
  localparam int AW = 8 * AB;
  localparam logic [AW-1:0] IDLE = AW'(16'h00FF);

  typedef enum logic [2:0] {
    S_PRE, S_START, S_DATA, S_ESTART, S_EDATA, S_END
  } state_t;

  state_t           state, state_nxt;
  logic             ack_d, adv;
  logic [4:0]       cnt;
  logic [7:0]       sh, err, byte_cur;
  logic [LEN_W-1:0] idx, act_len, buf_len;
  logic [AW-1:0]    act_data, buf_data;
  logic             buf_full, len_ok;
  logic             last_pre, last_bit, more;
  logic [3:0]       rep;

  assign adv       = ack & ~ack_d;
  assign pkt_ready = ~buf_full;
  assign len_ok    = (pkt_len != '0) &&
                     (pkt_len <= LEN_W'(MAX_BYTES));
  assign last_pre  = (cnt == 5'(PREAMBLE_BITS - 1));
  assign last_bit  = (cnt == 5'd7);
  assign more      = (idx != act_len);

  always_comb begin
    byte_cur = '0;
    for (int i = 0; i < AB; i++)
      if (idx == LEN_W'(i)) byte_cur = act_data[8*i +: 8];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_PRE:    if (last_pre) state_nxt = S_START;
      S_START:  state_nxt = S_DATA;
      S_DATA:   if (last_bit) state_nxt = more ? S_START : S_ESTART;
      S_ESTART: state_nxt = S_EDATA;
      S_EDATA:  if (last_bit) state_nxt = S_END;
      S_END:    state_nxt = S_PRE;
      default:  state_nxt = S_PRE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_PRE;
    else if (adv) state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_d     <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      err       <= '0;
      idx       <= '0;
      next_bit  <= 1'b1;
      act_data  <= IDLE;
      act_len   <= LEN_W'(2);
      rep       <= '0;
      busy_user <= 1'b0;
      buf_full  <= 1'b0;
      buf_data  <= '0;
      buf_len   <= '0;
      pkt_err   <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      ack_d    <= ack;
      pkt_err  <= 1'b0;
      pkt_done <= 1'b0;
      if (pkt_valid && !buf_full) begin
        if (len_ok) begin
          buf_full <= 1'b1;
          buf_data <= AW'(pkt_data);
          buf_len  <= pkt_len;
        end else begin
          pkt_err <= 1'b1;
        end
      end
      if (adv) begin
        unique case (state)
          S_PRE: begin
            if (last_pre) begin
              cnt      <= '0;
              next_bit <= 1'b0;
              sh       <= byte_cur;
              err      <= byte_cur;
              idx      <= idx + 1'b1;
            end else begin
              cnt      <= cnt + 1'b1;
              next_bit <= 1'b1;
            end
          end
          S_START, S_ESTART: begin
            cnt      <= '0;
            next_bit <= sh[7];
          end
          S_DATA: begin
            if (last_bit) begin
              cnt      <= '0;
              next_bit <= 1'b0;
              if (more) begin
                sh  <= byte_cur;
                err <= err ^ byte_cur;
                idx <= idx + 1'b1;
              end else begin
                sh <= err;
              end
            end else begin
              cnt      <= cnt + 1'b1;
              next_bit <= sh[6];
              sh       <= sh << 1;
            end
          end
          S_EDATA: begin
            if (last_bit) begin
              cnt      <= '0;
              next_bit <= 1'b1;
              idx      <= '0;
              // Next packet is chosen while the end bit is presented
              if (busy_user && rep > 4'd1) begin
                rep <= rep - 1'b1;
              end else begin
                pkt_done <= busy_user;
                if (buf_full) begin
                  act_data  <= buf_data;
                  act_len   <= buf_len;
                  rep       <= 4'(REPEAT);
                  busy_user <= 1'b1;
                  buf_full  <= 1'b0;
                end else begin
                  act_data  <= IDLE;
                  act_len   <= LEN_W'(2);
                  rep       <= '0;
                  busy_user <= 1'b0;
                end
              end
            end else begin
              cnt      <= cnt + 1'b1;
              next_bit <= sh[6];
              sh       <= sh << 1;
            end
          end
          S_END: begin
            cnt      <= '0;
            next_bit <= 1'b1;
          end
          default: begin
            cnt      <= '0;
            next_bit <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcc_packet_gen.sv
// Bench for dcc_packet_gen: packet-level bit-queue model plus literal
// wire captures of idle and user packets.
module tb_dcc_packet_gen;

  localparam int PB  = 14;
  localparam int MB  = 5;
  localparam int REP = 3;
  localparam int LW  = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [8*MB-1:0] pkt_data = '0;
  logic [LW-1:0]   pkt_len = '0;
  logic            pkt_valid = 1'b0;
  logic            ack = 1'b0;
  logic            pkt_ready, pkt_err, pkt_done;
  logic            busy_user, next_bit;

  always #5 clk = ~clk;

  dcc_packet_gen #(
    .PREAMBLE_BITS(PB),
    .MAX_BYTES(MB),
    .REPEAT(REP),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pkt_data(pkt_data),
    .pkt_len(pkt_len),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_err(pkt_err),
    .pkt_done(pkt_done),
    .busy_user(busy_user),
    .ack(ack),
    .next_bit(next_bit)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       bitq[$];
  logic       wire_q[$];
  logic [7:0] cur[$];
  logic [7:0] bufq[$];
  logic [7:0] idle_q[$];
  logic       m_busy, m_full, m_ready, m_done, m_err, prev_a;
  int         m_rep;
  int         done_cnt = 0;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] b[$]);
    logic [7:0] e = 8'h00;
    foreach (b[i]) e ^= b[i];
    return e;
  endfunction

  task automatic add_pkt(input logic [7:0] b[$]);
    logic [7:0] e;
    for (int i = 0; i < PB; i++) bitq.push_back(1'b1);
    foreach (b[i]) begin
      bitq.push_back(1'b0);
      for (int k = 7; k >= 0; k--) bitq.push_back(b[i][k]);
    end
    e = xor_of(b);
    bitq.push_back(1'b0);
    for (int k = 7; k >= 0; k--) bitq.push_back(e[k]);
    bitq.push_back(1'b1);
  endtask

  task automatic model_reset();
    idle_q = '{8'hFF, 8'h00};
    bitq.delete();
    cur = idle_q;
    add_pkt(cur);
    m_busy = 1'b0; m_full = 1'b0; m_ready = 1'b1;
    m_done = 1'b0; m_err = 1'b0; m_rep = 0; prev_a = 1'b0;
  endtask

  task automatic model_adv();
    void'(bitq.pop_front());
    if (bitq.size() == 1) begin
      if (m_busy && m_rep > 1) begin
        m_rep--;
      end else begin
        m_done = m_busy;
        if (m_full) begin
          cur = bufq; m_rep = REP; m_busy = 1'b1;
          m_full = 1'b0; m_ready = 1'b1;
        end else begin
          cur = idle_q; m_busy = 1'b0;
        end
      end
      add_pkt(cur);
    end
  endtask

  task automatic cyc(input logic a, input logic v,
                     input logic [8*MB-1:0] d, input logic [LW-1:0] l);
    logic adv, taken, old_ready;
    logic [8*MB-1:0] t;
    ack = a; pkt_valid = v; pkt_data = d; pkt_len = l;
    adv = a && !prev_a;
    taken = next_bit;
    old_ready = m_ready;
    @(posedge clk); #1;
    m_done = 1'b0; m_err = 1'b0; prev_a = a;
    if (pkt_done === 1'b1) done_cnt++;
    if (adv) begin
      wire_q.push_back(taken);
      model_adv();
    end
    if (v && old_ready) begin
      if (l != 0 && int'(l) <= MB) begin
        bufq.delete();
        for (int i = 0; i < int'(l); i++) begin
          t = d >> (8 * i);
          bufq.push_back(t[7:0]);
        end
        m_full = 1'b1; m_ready = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic adv_bit();
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic adv_load(input logic [8*MB-1:0] d,
                          input logic [LW-1:0] l);
    cyc(1'b1, 1'b1, d, l);
    cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_drain(input string n);
    int i;
    for (i = 0; i < 2000 && (m_busy || m_full); i++) adv_bit();
    chk({n, "_timeout"}, 64'(m_busy || m_full), 64'd0);
  endtask

  function automatic logic [41:0] grab(input int s);
    logic [41:0] g;
    for (int i = 0; i < 42; i++)
      g[41-i] = (s + i < wire_q.size()) ? wire_q[s+i] : 1'bx;
    return g;
  endfunction

  always @(negedge clk) begin
    chk("next_bit",  64'(next_bit),  64'(bitq[0]));
    chk("busy_user", 64'(busy_user), 64'(m_busy));
    chk("pkt_ready", 64'(pkt_ready), 64'(m_ready));
    chk("pkt_done",  64'(pkt_done),  64'(m_done));
    chk("pkt_err",   64'(pkt_err),   64'(m_err));
  end

  localparam logic [41:0] IDLE_BITS =
    42'b11111111111111_0_11111111_0_00000000_0_11111111_1;
  localparam logic [41:0] U0364_BITS =
    42'b11111111111111_0_00000011_0_01100100_0_01100111_1;

  initial begin
    logic [7:0] q[$];
    int r0, i;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    q = '{8'h03, 8'h64};
    chk("xor_0364", 64'(xor_of(q)), 64'h67);
    q = '{8'hC1, 8'h23, 8'h3F};
    chk("xor_c1233f", 64'(xor_of(q)), 64'hDD);

    // user packet loaded during the first idle preamble
    repeat (5) adv_bit();
    adv_load(40'h0000006403, 4'd2);
    wait_drain("t1");
    repeat (10) adv_bit();
    chk("wire_idle", 64'(grab(0)), 64'(IDLE_BITS));
    chk("wire_0364", 64'(grab(42)), 64'(U0364_BITS));
    chk("wire_0364_rep", 64'(grab(84)), 64'(U0364_BITS));
    chk("done_t1", 64'(done_cnt), 64'd1);

    adv_load(40'h00003F23C1, 4'd3);
    wait_drain("t2");
    chk("done_t2", 64'(done_cnt), 64'd2);

    // A accepted, B attempts while busy ignored, then B reloaded
    adv_load(40'h00000000A5, 4'd1);
    repeat (4) cyc(1'b0, 1'b1, 40'h0000003412, 4'd2);
    cyc(1'b0, 1'b0, '0, '0);
    for (i = 0; i < 200 && !m_ready; i++) adv_bit();
    chk("t3_ready", 64'(pkt_ready), 64'd1);
    adv_load(40'h0000003412, 4'd2);
    wait_drain("t3");
    chk("done_t3", 64'(done_cnt), 64'd4);

    // bad lengths
    cyc(1'b0, 1'b1, 40'h1122334455, 4'd0);
    cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 40'h1122334455, 4'd6);
    cyc(1'b0, 1'b0, '0, '0);
    chk("t4_ready", 64'(pkt_ready), 64'd1);
    repeat (50) adv_bit();

    // load on the selecting adv, then reset mid-DATA
    for (i = 0; i < 200 && bitq.size() != 2; i++) adv_bit();
    adv_load(40'h0044332211, 4'd4);
    chk("t5_wait_busy", 64'(m_busy), 64'd0);
    for (i = 0; i < 200 && !m_busy; i++) adv_bit();
    repeat (20) adv_bit();
    chk("t5_busy", 64'(busy_user), 64'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_next_bit", 64'(next_bit), 64'd1);
    chk("rst_ready", 64'(pkt_ready), 64'd1);
    chk("rst_busy", 64'(busy_user), 64'd0);
    chk("rst_done", 64'(pkt_done), 64'd0);
    chk("rst_err", 64'(pkt_err), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    r0 = wire_q.size();
    repeat (10) cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, '0, '0);
    repeat (55) adv_bit();
    chk("wire_post_rst", 64'(grab(r0)), 64'(IDLE_BITS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
